// File: rtl/reg_file_clr_if.sv
// reg_file_clr_if
//   Bundles the read/write/clear signals of reg_file_clr.
//   master : drives addresses, write data/enable and the clear request;
//            receives both read ports and busy.
//   slave  : the register file side (the opposite directions).
//   Parameters: WIDTH (data width), ADDR_W (address width).
interface reg_file_clr_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_w;
    logic [WIDTH-1:0]  w_data;
    logic              write_reg;
    logic              clr;
    logic [WIDTH-1:0]  r_data_a;
    logic [WIDTH-1:0]  r_data_b;
    logic              busy;

    modport master (
        output addr_a, addr_b, addr_w, w_data, write_reg, clr,
        input  r_data_a, r_data_b, busy
    );

    modport slave (
        input  addr_a, addr_b, addr_w, w_data, write_reg, clr,
        output r_data_a, r_data_b, busy
    );
endinterface

// File: rtl/reg_file_clr.sv
// reg_file_clr
//   2^ADDR_W x WIDTH register file with two combinational read ports, one
//   synchronous write port and a bulk-clear engine that zeroes registers
//   1..DEPTH-1, one per clock, while busy is high. Register 0 reads as 0.
//   Ports:
//     i_clk  - clock, rising edge
//     i_rst  - asynchronous active-high reset (all registers, FSM, index)
//     bus    - reg_file_clr_if.slave (addresses, write data/enable, clr,
//              read data A/B, busy)
//   Optional feature: define REG_BYPASS_EN to forward an accepted write's
//   data to any read port addressing the same register in the same cycle.
module reg_file_clr #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    reg_file_clr_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic              w_we;
    logic              w_clr_we;
    logic [WIDTH-1:0]  w_rd_a;
    logic [WIDTH-1:0]  w_rd_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Clr wins over a same-cycle write; once clearing, both writes and
    // further clr requests are ignored until the last register is zeroed.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_we        = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clr) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = ADDR_W'(1);
                end else if (bus.write_reg && (bus.addr_w != '0)) begin
                    w_we = 1'b1;
                end
            end
            CLEAR: begin
                w_clr_we  = 1'b1;
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Entry 0 is only ever written by reset; its reads are masked anyway.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_clr_we) begin
            r_regs[r_idx] <= '0;
        end else if (w_we) begin
            r_regs[bus.addr_w] <= bus.w_data;
        end
    end

    always_comb begin
        w_rd_a = (bus.addr_a == '0) ? '0 : r_regs[bus.addr_a];
        w_rd_b = (bus.addr_b == '0) ? '0 : r_regs[bus.addr_b];
`ifdef REG_BYPASS_EN
        // w_we already excludes busy, clr and address 0.
        if (w_we && (bus.addr_a == bus.addr_w)) w_rd_a = bus.w_data;
        if (w_we && (bus.addr_b == bus.addr_w)) w_rd_b = bus.w_data;
`endif
    end

    assign bus.r_data_a = w_rd_a;
    assign bus.r_data_b = w_rd_b;
    assign bus.busy     = (r_state == CLEAR);

endmodule

// File: tb/tb_reg_file_clr.sv
module tb_reg_file_clr;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    reg_file_clr_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file_clr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // Reference model: register contents plus the next register the clear
    // will zero (0 when no clear is running).
    logic [31:0] mdl [DEPTH];
    int          clr_k;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REG_BYPASS_EN
        if (clr_k == 0 && !bus.clr && bus.write_reg && bus.addr_w != 5'd0 && bus.addr_w == a)
            return bus.w_data;
`endif
        return mdl[a];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        clr_k = 0;
    endtask

    // One clock: check outputs at the falling edge, then apply the rising
    // edge to the model. Inputs are changed by callers at posedge+1.
    task automatic cyc();
        @(negedge i_clk);
        chk("rd_a", bus.r_data_a, exp_rd(bus.addr_a));
        chk("rd_b", bus.r_data_b, exp_rd(bus.addr_b));
        chk("busy", {31'd0, bus.busy}, (clr_k != 0) ? 32'd1 : 32'd0);
        if (bus.busy) busy_cnt++;
        @(posedge i_clk);
        if (clr_k != 0) begin
            mdl[clr_k] = 32'd0;
            clr_k = (clr_k == DEPTH - 1) ? 0 : clr_k + 1;
        end else if (bus.clr) begin
            clr_k = 1;
        end else if (bus.write_reg && bus.addr_w != 5'd0) begin
            mdl[bus.addr_w] = bus.w_data;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.write_reg = 1'b0;
        bus.clr       = 1'b0;
        i_rst = 1'b1;
        mdl_reset();
        #1;
        chk("rst_rd_a", bus.r_data_a, exp_rd(bus.addr_a));
        chk("rst_rd_b", bus.r_data_b, exp_rd(bus.addr_b));
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.write_reg = 1'b1;
        bus.addr_w    = a;
        bus.w_data    = d;
        cyc();
        bus.write_reg = 1'b0;
    endtask

    initial begin
        bus.addr_a = 5'd5;  bus.addr_b = 5'd31; bus.addr_w = 5'd0;
        bus.w_data = 32'd0; bus.write_reg = 1'b0; bus.clr = 1'b0;
        #2;
        do_reset();
        chk("rst_a_zero", bus.r_data_a, 32'd0);
        chk("rst_b_zero", bus.r_data_b, 32'd0);

        // Basic write/read and write to register 0.
        bus.addr_a = 5'd3; bus.addr_b = 5'd3;
        wr(5'd3, 32'hDEADBEEF);
        cyc();
        chk("wr3_a", bus.r_data_a, 32'hDEADBEEF);
        chk("wr3_b", bus.r_data_b, 32'hDEADBEEF);
        bus.addr_a = 5'd0;
        wr(5'd0, 32'h12345678);
        cyc();
        chk("wr0_a", bus.r_data_a, 32'd0);

        // Bulk clear with clr priority, dropped write and re-trigger.
        for (int k = 1; k < DEPTH; k++) wr(5'(k), 32'(k));
        bus.addr_a = 5'd10;
        busy_cnt = 0;
        bus.clr = 1'b1;
        wr(5'd2, 32'h0000BEEF);
        bus.clr = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            bus.addr_b = 5'($urandom_range(0, 31));
            if (c == 15) bus.clr = 1'b1;
            if (c == 5) wr(5'd7, 32'hAAAA5555);
            else cyc();
            bus.clr = 1'b0;
        end
        chk("busy_len", 32'(busy_cnt), 32'd31);
        for (int k = 0; k < DEPTH; k++) begin
            bus.addr_a = 5'(k); bus.addr_b = 5'(31 - k);
            #1;
            chk("clr_end", bus.r_data_a, 32'd0);
            cyc();
        end

        // Reset in the middle of a clear.
        for (int k = 1; k < DEPTH; k++) wr(5'(k), $urandom);
        bus.addr_a = 5'd25; bus.addr_b = 5'd30;
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        for (int c = 0; c < 12; c++) cyc();
        do_reset();
        chk("midrst_a", bus.r_data_a, 32'd0);
        bus.addr_a = 5'd20;
        wr(5'd20, 32'h55);
        cyc();
        chk("post_rst_wr", bus.r_data_a, 32'h55);

        // Forwarding behaviour.
        bus.addr_a = 5'd4;
        wr(5'd4, 32'h11);
        cyc();
        bus.write_reg = 1'b1; bus.addr_w = 5'd4; bus.w_data = 32'h99;
        #1;
`ifdef REG_BYPASS_EN
        chk("byp_pre", bus.r_data_a, 32'h99);
`else
        chk("byp_pre", bus.r_data_a, 32'h11);
`endif
        cyc();
        bus.write_reg = 1'b0;
        #1;
        chk("byp_post", bus.r_data_a, 32'h99);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bus.addr_a    = 5'($urandom_range(0, 31));
            bus.addr_b    = 5'($urandom_range(0, 31));
            bus.addr_w    = 5'($urandom_range(0, 31));
            bus.w_data    = $urandom;
            bus.write_reg = ($urandom_range(0, 1) == 1);
            bus.clr       = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else cyc();
        end
        bus.write_reg = 1'b0; bus.clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/reg_file_clr.md
# reg_file_clr

32 × 32-bit register file with two combinational read ports, one synchronous write port and a sequential bulk-clear engine. It sits directly upstream of the byte-select LED display stage and drives its two 32-bit data inputs R_Data_A and R_Data_B. Register 0 is hardwired to zero. A Clr request walks registers 1..31 one per cycle while reporting Busy.

## Interface
- WIDTH, 32, data width of each register and of the W_Data/R_Data ports
- ADDR_W, 5, address width; depth is 2^ADDR_W, with register 0 constant zero
- Clk  input  1  single clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high; clears all registers and the FSM
- Addr_A  input  ADDR_W  read address, port A
- Addr_B  input  ADDR_W  read address, port B
- Addr_W  input  ADDR_W  write address
- W_Data  input  WIDTH  write data
- Write_Reg  input  1  write enable
- Clr  input  1  bulk-clear request, sampled at the rising edge
- R_Data_A  output  WIDTH  contents of register Addr_A
- R_Data_B  output  WIDTH  contents of register Addr_B
- Busy  output  1  high while the clear sequence is running

## Operation
- Reads are purely combinational from current register contents.
- Address 0 always reads 0. Writes to address 0 are discarded.
- FSM states:
  - IDLE: writes accepted.
  - CLEAR: internal index Idx runs 1..31; writes blocked.
- IDLE → CLEAR at a rising edge with Clr=1. Idx loads 1. Any write presented in that same cycle is dropped, so Clr has priority.
- CLEAR: each edge writes 0 to register Idx, then increments Idx. At the edge that clears register 31, the FSM returns to IDLE.
- Busy = (state == CLEAR). It is a registered state decode, not a combinational function of Clr.
- Clr asserted while in CLEAR is ignored; the sequence does not restart.
- Write_Reg asserted while Busy is ignored; there is no queuing.
- Reset, at any time including mid-clear: all registers become 0, state goes to IDLE, Idx goes to 0, Busy goes to 0.
- Reset values: R_Data_A = 0, R_Data_B = 0 (all registers are zero), Busy = 0.

## Timing
- Read latency is 0 cycles: R_Data_x follows Addr_x combinationally.
- Write latency is 1 edge: data is visible on the read ports after the rising edge where Write_Reg=1, Addr_W≠0 and the FSM is in IDLE with Clr=0.
- Clear duration:
  - Busy rises after the Clr edge and stays high exactly 31 cycles.
  - Register k reads 0 after the k-th edge following the Clr edge.
  - Busy falls after the edge that clears register 31.
- First write accepted is on the first edge with Busy=0.
- A read of a register while the clear is in progress returns its old value until its clear edge.

## Configuration
- REG_BYPASS_EN defined:
  - Write-to-read forwarding is enabled. When a write will be accepted this cycle and Addr_x == Addr_W ≠ 0, R_Data_x = W_Data combinationally.
  - This applies to both ports independently.
  - No forwarding occurs while Busy or Clr is active, or for address 0.
- REG_BYPASS_EN undefined:
  - R_Data_x shows the pre-write value until the write edge.

## Test plan
- Reset then read: Reset=1, Addr_A=5, Addr_B=31 → R_Data_A=0, R_Data_B=0, Busy=0.
- Write/read: write 0xDEADBEEF to reg 3, then Addr_A=3 and Addr_B=3 → both ports read 0xDEADBEEF one edge later. Write 0x12345678 to reg 0 → Addr_A=0 reads 0.
- Bulk clear:
  - Setup: fill regs 1..31 with value k.
  - Stimulus: pulse Clr for one cycle.
  - Busy high for exactly 31 cycles.
  - Reg 10 reads 10 up to the 9th edge after the Clr edge and 0 from the 10th.
  - A write of 0xAAAA5555 to reg 7 issued while Busy is dropped.
  - All registers read 0 at the end.
- Clr priority and re-trigger:
  - Clr and a write to reg 2 in the same cycle → reg 2 stays at its cleared value of 0.
  - A second Clr pulse at Busy cycle 15 → Busy still falls after 31 cycles total.
- Reset mid-clear: assert Reset at cycle 12 of CLEAR → Busy=0 immediately and all registers read 0. After Reset is released, a write to reg 20 of 0x55 is accepted on the next edge.
- Bypass (REG_BYPASS_EN defined): reg 4 holds 0x11. Write 0x99 to reg 4 with Addr_A=4 → R_Data_A=0x99 before the edge. Without the macro → R_Data_A=0x11 before the edge and 0x99 after it.
